// File: rtl/alu_issue_stage.sv
// ID/EX register with operand forwarding, write-through capture and hazard stalls.
// Define ALU_FWD_EN for EX/MEM and MEM/WB forwarding; otherwise RAW hazards stall.
module alu_issue_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alusrc,
  input  logic [3:0]    id_aluop,
  input  logic [4:0]    id_shamt,
  input  logic [RW-1:0] id_wa,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          exm_regwrite,
  input  logic [RW-1:0] exm_wa,
  input  logic [DW-1:0] exm_result,
  input  logic          mwb_regwrite,
  input  logic [RW-1:0] mwb_wa,
  input  logic [DW-1:0] mwb_wdata,
  input  logic          flush,
  input  logic          ex_hold,
  output logic          id_stall,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_op,
  output logic [4:0]    alu_shamt,
  output logic [DW-1:0] ex_store_data,
  output logic          ex_valid,
  output logic [RW-1:0] ex_wa,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite
);
  localparam logic [3:0] ALU_NOP = 4'd0;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic          alusrc;
    logic [3:0]    aluop;
    logic [4:0]    shamt;
    logic [RW-1:0] wa;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
  } ex_t;

  ex_t           r_ex;
  ex_t           w_nxt;
  logic          w_lu;
  logic          w_hazard;
  logic [DW-1:0] w_fa;
  logic [DW-1:0] w_fb;

  assign w_lu = id_valid && r_ex.valid && r_ex.memread
             && (r_ex.wa != '0)
             && (r_ex.wa == id_rs || r_ex.wa == id_rt);

`ifdef ALU_FWD_EN
  assign w_hazard = w_lu;

  assign w_fa =
    (exm_regwrite && exm_wa != '0 && exm_wa == r_ex.rs) ? exm_result :
    (mwb_regwrite && mwb_wa != '0 && mwb_wa == r_ex.rs) ? mwb_wdata :
    r_ex.rd1;

  assign w_fb =
    (exm_regwrite && exm_wa != '0 && exm_wa == r_ex.rt) ? exm_result :
    (mwb_regwrite && mwb_wa != '0 && mwb_wa == r_ex.rt) ? mwb_wdata :
    r_ex.rd2;
`else
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_unused;

  // Producers in EX or EX/MEM are invisible until they reach MEM/WB.
  assign w_rs_hit = (id_rs != '0)
    && ((id_rs == r_ex.wa && r_ex.regwrite && r_ex.valid)
     || (id_rs == exm_wa && exm_regwrite));
  assign w_rt_hit = (id_rt != '0)
    && ((id_rt == r_ex.wa && r_ex.regwrite && r_ex.valid)
     || (id_rt == exm_wa && exm_regwrite));

  assign w_hazard = w_lu || (id_valid && (w_rs_hit || w_rt_hit));
  assign w_fa     = r_ex.rd1;
  assign w_fb     = r_ex.rd2;
  assign w_unused = ^{r_ex.rs, r_ex.rt, exm_result};
`endif

  assign id_stall = w_hazard || ex_hold;

  always_comb begin
    w_nxt       = '0;
    w_nxt.aluop = ALU_NOP;
    if (!rst && !flush && !w_hazard && id_valid) begin
      w_nxt.valid    = 1'b1;
      w_nxt.rs       = id_rs;
      w_nxt.rt       = id_rt;
      w_nxt.rd1      = (mwb_regwrite && mwb_wa != '0 && mwb_wa == id_rs)
                     ? mwb_wdata : id_rd1;
      w_nxt.rd2      = (mwb_regwrite && mwb_wa != '0 && mwb_wa == id_rt)
                     ? mwb_wdata : id_rd2;
      w_nxt.imm      = id_imm;
      w_nxt.alusrc   = id_alusrc;
      w_nxt.aluop    = id_aluop;
      w_nxt.shamt    = id_shamt;
      w_nxt.wa       = id_wa;
      w_nxt.regwrite = id_regwrite;
      w_nxt.memread  = id_memread;
      w_nxt.memwrite = id_memwrite;
    end
  end

  // Reset and flush load the bubble; a hold keeps the current entry.
  always_ff @(posedge clk) begin
    if (rst || flush || !ex_hold) begin
      r_ex <= w_nxt;
    end
  end

  assign alu_a         = w_fa;
  assign alu_b         = r_ex.alusrc ? r_ex.imm : w_fb;
  assign ex_store_data = w_fb;
  assign alu_op        = r_ex.aluop;
  assign alu_shamt     = r_ex.shamt;
  assign ex_valid      = r_ex.valid;
  assign ex_wa         = r_ex.wa;
  assign ex_regwrite   = r_ex.regwrite;
  assign ex_memread    = r_ex.memread;
  assign ex_memwrite   = r_ex.memwrite;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed cases then random traffic.
// Reference model tracks the EX slot and register visibility per build.
module tb_alu_issue_stage;
  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, id_alusrc, id_regwrite;
  logic        id_memread, id_memwrite;
  logic [4:0]  id_rs, id_rt, id_wa, id_shamt, exm_wa, mwb_wa;
  logic [31:0] id_rd1, id_rd2, id_imm, exm_result, mwb_wdata;
  logic [3:0]  id_aluop;
  logic        exm_regwrite, mwb_regwrite, flush, ex_hold;
  logic        id_stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt, ex_wa;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_alusrc(id_alusrc), .id_aluop(id_aluop),
    .id_shamt(id_shamt), .id_wa(id_wa), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite),
    .exm_regwrite(exm_regwrite), .exm_wa(exm_wa),
    .exm_result(exm_result), .mwb_regwrite(mwb_regwrite),
    .mwb_wa(mwb_wa), .mwb_wdata(mwb_wdata), .flush(flush),
    .ex_hold(ex_hold), .id_stall(id_stall), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid),
    .ex_wa(ex_wa), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite)
  );

  typedef struct {
    bit rst, v, src, rw, mr, mw, xrw, wrw, flush, hold;
    bit [4:0] rs, rt, wa, sh, xwa, wwa;
    bit [31:0] rd1, rd2, imm, xres, wdat;
    bit [3:0] op;
  } stim_t;

  typedef struct {
    bit v, src, rw, mr, mw;
    bit [4:0] rs, rt, wa, sh;
    bit [31:0] a, b, imm;
    bit [3:0] op;
  } slot_t;

  typedef struct {
    bit stall, v, rw, mr, mw;
    bit [31:0] a, b, sd;
    bit [3:0] op;
    bit [4:0] sh, wa;
  } exp_t;

  slot_t m;
  bit    known = 1'b0;
  exp_t  q[$];
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic slot_t bubble();
    slot_t b;
    b = '{default: '0};
    b.op = ALU_NOP;
    return b;
  endfunction

  // Value of register r as EX sees it, given what is in flight.
  function automatic bit [31:0] seen(bit [4:0] r, bit [31:0] held,
                                     stim_t s);
`ifdef ALU_FWD_EN
    if (r != 0 && s.xrw && s.xwa == r) return s.xres;
    if (r != 0 && s.wrw && s.wwa == r) return s.wdat;
`endif
    return held;
  endfunction

  // ID must wait if a source is written by something not yet visible.
  function automatic bit hazard(stim_t s);
    bit [4:0] src [2];
    if (!s.v) return 1'b0;
    src[0] = s.rs;
    src[1] = s.rt;
    for (int i = 0; i < 2; i++) begin
      if (src[i] != 0) begin
        if (m.v && m.mr && m.wa == src[i]) return 1'b1;
`ifndef ALU_FWD_EN
        if (m.v && m.rw && m.wa == src[i]) return 1'b1;
        if (s.xrw && s.xwa == src[i]) return 1'b1;
`endif
      end
    end
    return 1'b0;
  endfunction

  task automatic step(input stim_t s);
    exp_t  e;
    bit    hz;
    bit [31:0] rtv;
    @(posedge clk);
    #1;
    rst = s.rst; id_valid = s.v; id_rs = s.rs; id_rt = s.rt;
    id_rd1 = s.rd1; id_rd2 = s.rd2; id_imm = s.imm;
    id_alusrc = s.src; id_aluop = s.op; id_shamt = s.sh;
    id_wa = s.wa; id_regwrite = s.rw; id_memread = s.mr;
    id_memwrite = s.mw; exm_regwrite = s.xrw; exm_wa = s.xwa;
    exm_result = s.xres; mwb_regwrite = s.wrw; mwb_wa = s.wwa;
    mwb_wdata = s.wdat; flush = s.flush; ex_hold = s.hold;
    hz = hazard(s);
    if (known) begin
      rtv     = seen(m.rt, m.b, s);
      e.stall = hz || s.hold;
      e.a     = seen(m.rs, m.a, s);
      e.b     = m.src ? m.imm : rtv;
      e.sd    = rtv;
      e.op    = m.op;
      e.sh    = m.sh;
      e.v     = m.v;
      e.wa    = m.wa;
      e.rw    = m.rw;
      e.mr    = m.mr;
      e.mw    = m.mw;
      q.push_back(e);
    end
    if (s.rst) begin
      m = bubble();
      known = 1'b1;
    end else if (s.flush) begin
      m = bubble();
    end else if (!s.hold) begin
      if (hz || !s.v) begin
        m = bubble();
      end else begin
        m.v   = 1'b1;
        m.rs  = s.rs;
        m.rt  = s.rt;
        m.a   = (s.wrw && s.wwa != 0 && s.wwa == s.rs) ? s.wdat : s.rd1;
        m.b   = (s.wrw && s.wwa != 0 && s.wwa == s.rt) ? s.wdat : s.rd2;
        m.imm = s.imm;
        m.src = s.src;
        m.op  = s.op;
        m.sh  = s.sh;
        m.wa  = s.wa;
        m.rw  = s.rw;
        m.mr  = s.mr;
        m.mw  = s.mw;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("id_stall", 32'(id_stall), 32'(e.stall));
      chk("alu_a", alu_a, e.a);
      chk("alu_b", alu_b, e.b);
      chk("store", ex_store_data, e.sd);
      chk("alu_op", 32'(alu_op), 32'(e.op));
      chk("shamt", 32'(alu_shamt), 32'(e.sh));
      chk("ex_valid", 32'(ex_valid), 32'(e.v));
      chk("ex_wa", 32'(ex_wa), 32'(e.wa));
      chk("ex_ctl", {29'd0, ex_regwrite, ex_memread, ex_memwrite},
          {29'd0, e.rw, e.mr, e.mw});
    end
  end

  function automatic stim_t rnd();
    stim_t s;
    s.rst   = ($urandom_range(0, 99) == 0);
    s.v     = ($urandom_range(0, 9) != 0);
    s.rs    = 5'($urandom_range(0, 3));
    s.rt    = 5'($urandom_range(0, 3));
    s.wa    = 5'($urandom_range(0, 3));
    s.sh    = 5'($urandom);
    s.rd1   = $urandom;
    s.rd2   = $urandom;
    s.imm   = $urandom;
    s.src   = 1'($urandom);
    s.op    = 4'($urandom_range(1, 15));
    s.rw    = ($urandom_range(0, 3) != 0);
    s.mr    = ($urandom_range(0, 3) == 0);
    s.mw    = ($urandom_range(0, 7) == 0);
    s.xrw   = 1'($urandom);
    s.xwa   = 5'($urandom_range(0, 3));
    s.xres  = $urandom;
    s.wrw   = 1'($urandom);
    s.wwa   = 5'($urandom_range(0, 3));
    s.wdat  = $urandom;
    s.flush = ($urandom_range(0, 9) == 0);
    s.hold  = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    step(s);
    step(s);
    step(idle());
    step(idle());
    @(negedge clk);
    chk("rst_op", 32'(alu_op), 32'(ALU_NOP));
    chk("rst_a", alu_a, 32'd0);
    chk("rst_b", alu_b, 32'd0);
    chk("rst_stall", 32'(id_stall), 32'd0);
    chk("rst_valid", 32'(ex_valid), 32'd0);

    s = idle();
    s.v = 1; s.rs = 1; s.rt = 2; s.wa = 3; s.rd1 = 5; s.rd2 = 7;
    s.op = ALU_ADD; s.rw = 1;
    step(s);
    step(idle());
    @(negedge clk);
    chk("add_a", alu_a, 32'd5);
    chk("add_b", alu_b, 32'd7);
    chk("add_op", 32'(alu_op), 32'(ALU_ADD));
    chk("add_wa", 32'(ex_wa), 32'd3);

    s = idle();
    s.v = 1; s.rs = 1; s.wa = 4; s.mr = 1; s.rw = 1;
    s.op = ALU_ADD; s.src = 1; s.imm = 8;
    step(s);
    s = idle();
    s.v = 1; s.rs = 2; s.rt = 4; s.wa = 6; s.op = ALU_ADD; s.rw = 1;
    s.rd1 = 32'h11; s.rd2 = 32'h22;
    step(s);
    @(negedge clk);
    chk("lu_stall", 32'(id_stall), 32'd1);
    s.xrw = 1; s.xwa = 4; s.xres = 32'h99;
    step(s);
    s.xrw = 0; s.wrw = 1; s.wwa = 4; s.wdat = 32'h77;
    step(s);
    step(s);
    step(idle());

    s = idle();
    s.v = 1; s.rs = 1; s.rt = 2; s.wa = 5; s.op = ALU_SUB; s.rw = 1;
    s.rd1 = 32'h30; s.rd2 = 32'h10;
    step(s);
    s = idle();
    s.hold = 1;
    step(s);
    s.flush = 1;
    step(s);
    s.flush = 0;
    step(s);
    @(negedge clk);
    chk("flush_op", 32'(alu_op), 32'(ALU_NOP));

    s = idle();
    s.v = 1; s.rs = 1; s.rt = 0; s.src = 1; s.imm = 32'h0000FFFF;
    s.op = ALU_OR; s.rd1 = 32'h5; s.rd2 = 32'h1234; s.rw = 1; s.wa = 2;
    step(s);
    s = idle();
    s.xrw = 1; s.xwa = 0; s.xres = 32'hDEAD;
    step(s);
    @(negedge clk);
    chk("ori_b", alu_b, 32'h0000FFFF);
    chk("ori_sd", ex_store_data, 32'h1234);

`ifdef ALU_FWD_EN
    s = idle();
    s.v = 1; s.rs = 1; s.rt = 2; s.wa = 3; s.op = ALU_ADD; s.rw = 1;
    s.rd1 = 32'h1; s.rd2 = 32'h2;
    step(s);
    s = idle();
    s.hold = 1; s.xrw = 1; s.xwa = 1; s.xres = 32'h10;
    s.wrw = 1; s.wwa = 1; s.wdat = 32'h20;
    step(s);
    @(negedge clk);
    chk("fwd_exm", alu_a, 32'h10);
    s.xwa = 0;
    step(s);
    @(negedge clk);
    chk("fwd_mwb", alu_a, 32'h20);
`endif

    for (int i = 0; i < 3000; i++) step(rnd());
    step(idle());
    step(idle());
    @(negedge clk);
    #1;
    chk("sb_drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline register plus operand-select logic directly upstream of the ALU.
- Captures decoded operands and control from ID and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles.
- Drives the ALU A, B, ALUOp and shamt inputs, and the store data for MEM.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  RW  source register numbers.
- id_rd1, id_rd2  in  DW  register-file read data.
- id_imm  in  DW  extended immediate.
- id_alusrc  in  1  B = immediate when 1.
- id_aluop  in  4  ALU operation code, from the ctrl_encode_def.v ALU_* codes.
- id_shamt  in  5  shift amount.
- id_wa  in  RW  destination register.
- id_regwrite, id_memread, id_memwrite  in  1  control bits.
- exm_regwrite, exm_wa, exm_result  in  1/RW/DW  EX/MEM producer.
- mwb_regwrite, mwb_wa, mwb_wdata  in  1/RW/DW  MEM/WB producer.
- flush  in  1  kill the instruction entering EX (branch/jump).
- ex_hold  in  1  downstream stall; freeze the EX register.
- id_stall  out  1  freeze PC and IF/ID this cycle.
- alu_a, alu_b  out  DW  ALU operands.
- alu_op  out  4  ALU operation code.
- alu_shamt  out  5  ALU shift amount.
- ex_store_data  out  DW  forwarded rt value for SW.
- ex_valid, ex_wa, ex_regwrite, ex_memread, ex_memwrite  out  registered EX control.

Behaviour:
- Registers: ex_valid, ex_rs, ex_rt, ex_rd1, ex_rd2, ex_imm, ex_alusrc, ex_aluop, ex_shamt, ex_wa, ex_regwrite, ex_memread, ex_memwrite.
- Reset: all registers 0; ex_aluop = ALU_NOP. Outputs after reset: alu_a = alu_b = ex_store_data = 0, alu_op = ALU_NOP, id_stall = 0.
- Bubble: ex_valid, ex_regwrite, ex_memread and ex_memwrite all 0, ex_aluop = ALU_NOP, ex_wa = 0. Data fields are don't-care but are zeroed.
- Per-edge priority: rst > flush (load bubble) > ex_hold (hold all) > load-use stall (load bubble) > capture ID.
- Capture write-through: when mwb_regwrite=1, mwb_wa!=0 and mwb_wa==id_rs, capture mwb_wdata into ex_rd1 instead of id_rd1. Same rule for id_rt into ex_rd2.
- Load-use: id_stall = id_valid & ex_valid & ex_memread & ex_wa!=0 & (ex_wa==id_rs | ex_wa==id_rt). Also id_stall = 1 whenever ex_hold = 1.
- Forwarding (combinational, EX stage), for operand X in {rs, rt}:
  - if exm_regwrite & exm_wa!=0 & exm_wa==ex_X, use exm_result;
  - else if mwb_regwrite & mwb_wa!=0 & mwb_wa==ex_X, use mwb_wdata;
  - else use the registered value.
  - EX/MEM wins when both match. Register 0 is never forwarded.
- alu_a = forwarded rs. alu_b = ex_imm if ex_alusrc, else forwarded rt. ex_store_data = forwarded rt, always.
- alu_op = ex_aluop; alu_shamt = ex_shamt; latency ID→ALU is 1 cycle.
- flush and load-use in the same cycle: the bubble is inserted; id_stall still follows its formula.
- flush during ex_hold: flush wins and the EX contents are lost.
- rst mid-stall: the next cycle is the reset state with id_stall = 0.

Optional Feature:
- ALU_FWD_EN defined: forwarding exactly as above.
- Not defined:
  - Forwarding muxes removed; operands come from the registered values only.
  - id_stall additionally asserts when id_valid and a nonzero id_rs or id_rt matches ex_wa (with ex_regwrite & ex_valid) or exm_wa (with exm_regwrite).
  - A bubble is inserted each such cycle.
  - The MEM/WB capture write-through stays in both builds.

Test Plan:
- Reset, then idle → alu_op = ALU_NOP, alu_a = alu_b = 0, id_stall = 0, ex_valid = 0.
- ADD $3,$1,$2 with id_rd1 = 5, id_rd2 = 7, no hazards → next cycle alu_a = 5, alu_b = 7, alu_op = ALU_ADD, ex_wa = 3.
- EX/MEM writes $1 = 0x10 and MEM/WB writes $1 = 0x20 while EX holds rs = $1 (FWD_EN) → alu_a = 0x10. Same case with exm_wa = 0 → alu_a = 0x20.
- LW $4 in EX, ID issues ADD using rt = $4 → id_stall = 1 for one cycle, EX gets a bubble, then ADD enters EX. Without ALU_FWD_EN, the stall lasts 2 cycles.
- ex_hold = 1 for 3 cycles with SUB in EX → alu_* stable, id_stall = 1 throughout. Asserting flush in cycle 2 → bubble with alu_op = ALU_NOP.
- ORI with id_alusrc = 1, id_imm = 0x0000FFFF, rt = $0, exm_wa = 0 with regwrite → alu_b = 0x0000FFFF, ex_store_data = id_rd2 (no $0 forwarding).
